key_bounce_generator: RTL
=========================

Name: key_bounce_generator

Overview:
- Emulates a mechanical push-switch contact for the key inputs: takes a clean requested level and drives a contact-bounce waveform onto `bounce_out`.
- Waveform is pseudo-random but deterministic for a given seed: a burst of toggles, then a settled final level.
- Used in sim benches and on-board loopback to stimulate the debounce and bounce-detector logic.
- Sits on the transmit side of the key input path: output is active-low like a real key and idles high.

Parameters:
- BOUNCE_CYCLES, 24000, length of the bounce window in clock cycles (2 ms at 12 MHz); must be >= 1.
- TOGGLE_MIN, 64, minimum cycles between successive bounce toggles; must be >= 1.
- TOGGLE_MASK, 1023, 2^k-1 mask for the random interval; interval = TOGGLE_MIN + (lfsr[15:0] & TOGGLE_MASK).
- SETTLE_CYCLES, 12000, hold-off after the window during which level_in is ignored.
- IDLE_LEVEL, 1, `bounce_out` and stable-level value after reset.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = bounce emulation; 0 = registered pass-through.
- level_in  in  1  requested clean contact level, synchronous to clock.
- bounce_out  out  1  emulated contact output.
- busy  out  1  high in BOUNCE or SETTLE.
- toggle_count  out  8  toggles issued in the current/last event, saturating at 255.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - bounce_out=IDLE_LEVEL, stable=IDLE_LEVEL, target=IDLE_LEVEL.
  - busy=0, toggle_count=0, state=IDLE, lfsr=LFSR_SEED, all counters 0.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Advances every cycle out of reset, regardless of state or enable.
- enable=0:
  - bounce_out <= level_in each cycle (1-cycle latency); stable <= level_in.
  - State forced to IDLE, busy=0, toggle_count unchanged.
  - Dropping enable mid-event aborts the event the next cycle.
- State IDLE (enable=1):
  - When level_in != stable, go to BOUNCE on the next edge.
  - On that edge: target <= level_in, bounce_out <= ~bounce_out (first edge, 1-cycle latency), toggle_count <= 1.
  - Also: window counter <= BOUNCE_CYCLES-1, interval counter <= TOGGLE_MIN + (lfsr & TOGGLE_MASK) - 1, busy <= 1.
- State BOUNCE:
  - Window counter decrements every cycle.
  - When the interval counter reaches 0 and the window counter is non-zero: toggle bounce_out, toggle_count += 1 (saturate), reload the interval from the current lfsr.
  - level_in changes in BOUNCE update target every cycle; the window is not restarted.
  - When the window counter reaches 0: bounce_out <= target. This counts as a toggle only if the value changes. Then load settle counter <= SETTLE_CYCLES-1 and go to SETTLE.
  - Window end and interval expiry in the same cycle: window end wins, no extra toggle.
- State SETTLE:
  - bounce_out held; level_in ignored; counter decrements.
  - At 0: stable <= bounce_out, busy <= 0, go to IDLE.
  - A level_in that still differs from stable starts a new event from IDLE one cycle later.
- Invariants:
  - bounce_out == target at the end of every completed event.
  - No two toggles closer than TOGGLE_MIN cycles.
  - Counters are sized by $clog2 of their parameters.

Test Plan:
- Reset: hold reset_n=0 with level_in=0, enable=1 -> bounce_out=1, busy=0, toggle_count=0. Release -> still 1 and idle until level_in is sampled the next cycle.
- Pass-through: enable=0, level_in 1->0->1 with 5-cycle gaps -> bounce_out follows with exactly 1 cycle of latency, busy stays 0, toggle_count=0.
- Press burst: enable=1, BOUNCE_CYCLES=200, TOGGLE_MIN=4, TOGGLE_MASK=15, SETTLE_CYCLES=50; level_in 1->0.
  - First bounce_out edge 1 cycle later.
  - All toggle spacings in [4,19].
  - bounce_out=0 from cycle 201 onward.
  - busy high for 250 cycles.
  - toggle_count odd.
- Mid-burst release: same config, level_in 1->0, then back to 1 at cycle 100 -> final bounce_out=1 at window end, toggle_count even, no window restart (busy still 250 cycles).
- SETTLE hold-off: level_in toggles during SETTLE -> no bounce_out change until SETTLE ends. Then a new event starts 1 cycle after IDLE if level_in != stable.
- Determinism and reset mid-BOUNCE: assert reset_n at cycle 60 of a burst -> bounce_out=1, busy=0 immediately. Repeat the same stimulus -> toggle timing identical to the first run cycle-for-cycle.

Source files
------------

// File: rtl/key_bounce_generator.sv
// rtl/key_bounce_generator.sv - emulated push-switch contact with seeded pseudo-random bounce burst
module key_bounce_generator #(
    parameter int          BOUNCE_CYCLES = 24000,
    parameter int          TOGGLE_MIN    = 64,
    parameter int          TOGGLE_MASK   = 1023,
    parameter int          SETTLE_CYCLES = 12000,
    parameter logic        IDLE_LEVEL    = 1'b1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       level_in,
    output logic       bounce_out,
    output logic       busy,
    output logic [7:0] toggle_count
);

    localparam int WW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int IW = ((TOGGLE_MIN + TOGGLE_MASK) > 1) ? $clog2(TOGGLE_MIN + TOGGLE_MASK) : 1;
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [WW-1:0] WIN_LOAD = WW'(BOUNCE_CYCLES - 1);
    localparam logic [SW-1:0] SET_LOAD = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BOUNCE = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;

    logic [1:0]    state;
    logic [15:0]   lfsr;
    logic          stable;
    logic          target;
    logic [WW-1:0] win_cnt;
    logic [IW-1:0] int_cnt;
    logic [SW-1:0] set_cnt;
    logic [IW-1:0] int_reload;
    logic [7:0]    cnt_inc;

    // Interval counter is loaded with (interval - 1) so a toggle lands exactly interval cycles later.
    assign int_reload = IW'(TOGGLE_MIN - 1) + IW'(lfsr & 16'(TOGGLE_MASK));
    assign cnt_inc    = (toggle_count == 8'hFF) ? 8'hFF : toggle_count + 8'd1;

    // Galois LFSR, x^16+x^14+x^13+x^11, free-running so timing depends only on cycles since reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            bounce_out   <= IDLE_LEVEL;
            stable       <= IDLE_LEVEL;
            target       <= IDLE_LEVEL;
            busy         <= 1'b0;
            toggle_count <= 8'd0;
            win_cnt      <= '0;
            int_cnt      <= '0;
            set_cnt      <= '0;
        end else if (!enable) begin
            bounce_out <= level_in;
            stable     <= level_in;
            target     <= level_in;
            busy       <= 1'b0;
            state      <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (level_in != stable) begin
                        state        <= ST_BOUNCE;
                        target       <= level_in;
                        bounce_out   <= ~bounce_out;
                        toggle_count <= 8'd1;
                        win_cnt      <= WIN_LOAD;
                        int_cnt      <= int_reload;
                        busy         <= 1'b1;
                    end
                end
                ST_BOUNCE: begin
                    // Window end has priority over a coincident interval expiry.
                    if (win_cnt == '0) begin
                        if (bounce_out != target) begin
                            toggle_count <= cnt_inc;
                        end
                        bounce_out <= target;
                        set_cnt    <= SET_LOAD;
                        state      <= ST_SETTLE;
                    end else begin
                        win_cnt <= win_cnt - WW'(1);
                        target  <= level_in;
                        if (int_cnt == '0) begin
                            bounce_out   <= ~bounce_out;
                            toggle_count <= cnt_inc;
                            int_cnt      <= int_reload;
                        end else begin
                            int_cnt <= int_cnt - IW'(1);
                        end
                    end
                end
                ST_SETTLE: begin
                    if (set_cnt == '0) begin
                        stable <= bounce_out;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        set_cnt <= set_cnt - SW'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
